// File: rtl/seq_sdiv_8bit.sv
// Signed restoring divider: magnitudes are divided MSB-first one bit per clock, then signs are reapplied.
// Divide-by-zero and the -2^(W-1)/-1 overflow bypass the iteration and complete straight from IDLE.
module seq_sdiv_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_MAX = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE = CW'(1);
    localparam logic [WIDTH-1:0] Q_ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_sign_n;
    logic             r_sign_d;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH:0]   r_b;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_zero;
    logic             r_ovf;

    logic             w_accept;
    logic             w_dz;
    logic             w_ovf;
    logic [WIDTH-1:0] w_abs_n;
    logic [WIDTH-1:0] w_abs_d;
    logic [WIDTH+1:0] w_rp;
    logic [WIDTH+1:0] w_t;

    // A magnitude of 2^(W-1) still fits WIDTH bits when read as unsigned.
    assign w_abs_n  = dividend[WIDTH-1] ? -dividend : dividend;
    assign w_abs_d  = divisor[WIDTH-1]  ? -divisor  : divisor;
    assign w_dz     = (divisor == '0);
    assign w_ovf    = (dividend == MOST_NEG) && (divisor == '1);
    assign w_accept = in_valid && in_ready;

    assign w_rp = {r_rem, r_a[r_cnt]};
    assign w_t  = w_rp - {1'b0, r_b};

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign div_zero  = r_div_zero;
    assign ovf       = r_ovf;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = (w_dz || w_ovf) ? S_DONE : S_CALC;
            S_CALC:  if (r_cnt == '0) w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign_n    <= 1'b0;
            r_sign_d    <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sign_n <= dividend[WIDTH-1];
                        r_sign_d <= divisor[WIDTH-1];
                        r_a      <= w_abs_n;
                        r_b      <= {1'b0, w_abs_d};
                        r_rem    <= '0;
                        r_q      <= '0;
                        r_cnt    <= CNT_MAX;
                        if (w_dz) begin
                            r_quotient  <= dividend[WIDTH-1] ? Q_ONE : '1;
                            r_remainder <= dividend;
                            r_div_zero  <= 1'b1;
                            r_ovf       <= 1'b0;
                        end else if (w_ovf) begin
                            r_quotient  <= dividend;
                            r_remainder <= '0;
                            r_div_zero  <= 1'b0;
                            r_ovf       <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    // Negative trial difference means the subtraction is undone.
                    r_rem      <= w_t[WIDTH+1] ? w_rp[WIDTH:0] : w_t[WIDTH:0];
                    r_q[r_cnt] <= ~w_t[WIDTH+1];
                    r_cnt      <= r_cnt - CNT_ONE;
                end
                S_FIX: begin
                    r_quotient  <= (r_sign_n ^ r_sign_d) ? -r_q : r_q;
                    r_remainder <= r_sign_n ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
                    r_div_zero  <= 1'b0;
                    r_ovf       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_sdiv_8bit.sv
// Directed and swept checks of seq_sdiv_8bit against a truncating-division reference model.
module tb_seq_sdiv_8bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_zero;
    logic       ovf;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ov;
        int         lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    seq_sdiv_8bit #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .ovf       (ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_expected(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   ia;
        int   ib;
        ia = int'($signed(a));
        ib = int'($signed(b));
        e.dz = 1'b0;
        e.ov = 1'b0;
        if (ib == 0) begin
            e.q   = (ia < 0) ? 8'h01 : 8'hFF;
            e.r   = a;
            e.dz  = 1'b1;
            e.lat = 0;
        end else if (ia == -128 && ib == -1) begin
            e.q   = 8'h80;
            e.r   = 8'h00;
            e.ov  = 1'b1;
            e.lat = 0;
        end else begin
            e.q   = 8'(ia / ib);
            e.r   = 8'(ia % ib);
            e.lat = 9;
        end
        sb.push_back(e);
    endtask

    // Present operands, wait for the accept edge, then scramble the inputs.
    task automatic drive_accept(input logic [7:0] a, input logic [7:0] b, input bit push);
        int w;
        if (push) push_expected(a, b);
        @(negedge clk);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("accept_timeout", {31'b0, w < 50}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
    endtask

    // Count edges after the accept edge until out_valid, then score the result.
    task automatic wait_result(input string tag);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_latency"},  n,                   e.lat);
        check({tag, "_q"},        {24'b0, quotient},   {24'b0, e.q});
        check({tag, "_r"},        {24'b0, remainder},  {24'b0, e.r});
        check({tag, "_div_zero"}, {31'b0, div_zero},   {31'b0, e.dz});
        check({tag, "_ovf"},      {31'b0, ovf},        {31'b0, e.ov});
        check({tag, "_in_ready"}, {31'b0, in_ready},   32'd0);
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_post_out_valid"}, {31'b0, out_valid}, 32'd0);
        check({tag, "_post_in_ready"},  {31'b0, in_ready},  32'd1);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input string tag);
        drive_accept(a, b, 1'b1);
        wait_result(tag);
        release_result(tag);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = 8'h00;
        divisor   = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready",  {31'b0, in_ready},  32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_q",         {24'b0, quotient},  32'd0);
        check("rst_r",         {24'b0, remainder}, 32'd0);
        check("rst_div_zero",  {31'b0, div_zero},  32'd0);
        check("rst_ovf",       {31'b0, ovf},       32'd0);

        run_op(8'd100,  8'd7,   "p100_7");
        run_op(8'h9C,   8'd7,   "m100_7");
        run_op(8'd100,  8'hF9,  "p100_m7");
        run_op(8'h80,   8'd1,   "m128_1");
        run_op(8'd5,    8'd0,   "p5_0");
        run_op(8'hFB,   8'd0,   "m5_0");
        run_op(8'h80,   8'hFF,  "ovf");
        run_op(8'h80,   8'h80,  "m128_m128");
        run_op(8'd127,  8'h80,  "p127_m128");
        run_op(8'h00,   8'd0,   "zero_0");

        // Result held under backpressure while a new request waits.
        drive_accept(8'd100, 8'd7, 1'b1);
        wait_result("hold");
        in_valid = 1'b1;
        dividend = 8'd9;
        divisor  = 8'd4;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_out_valid", {31'b0, out_valid}, 32'd1);
            check("hold_in_ready",  {31'b0, in_ready},  32'd0);
            check("hold_q",         {24'b0, quotient},  32'h0E);
            check("hold_r",         {24'b0, remainder}, 32'h02);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("hold_idle_in_ready",  {31'b0, in_ready},  32'd1);
        check("hold_idle_out_valid", {31'b0, out_valid}, 32'd0);
        push_expected(8'd9, 8'd4);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_result("hold_next");
        release_result("hold_next");

        // Reset in the middle of an iteration discards the operation.
        drive_accept(8'd100, 8'd7, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready",  {31'b0, in_ready},  32'd1);
        check("abort_out_valid", {31'b0, out_valid}, 32'd0);
        check("abort_q",         {24'b0, quotient},  32'd0);
        check("abort_r",         {24'b0, remainder}, 32'd0);
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("abort_stays_idle", {31'b0, out_valid}, 32'd0);
        run_op(8'd7, 8'd2, "after_abort");

        for (int ai = -128; ai < 128; ai += 17) begin
            for (int bi = -128; bi < 128; bi++) begin
                run_op(ai[7:0], bi[7:0], "sweep");
            end
        end
        for (int k = 0; k < 200; k++) begin
            run_op(8'($urandom), 8'($urandom), "rand");
        end

        check("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
